// File: rtl/sw_led_fsm.sv
// sw_led_fsm: Moore FSM stepping through five states on exact switch codes, LEDs identify the state
module sw_led_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  output logic [2:0] led
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ST1  = 3'd1,
    ST2  = 3'd2,
    ST3  = 3'd3,
    ST4  = 3'd4
  } state_e;
  // plain vector register so unused encodings (5..7) stay representable and recover
  logic [2:0] state_q, state_d;
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    led     = 3'b000;
    case (state_q)
      IDLE: state_d = (sw == 3'b001) ? ST1 : (sw == 3'b010) ? ST2 : state_q;
      ST1: begin
        led     = 3'b001;
        state_d = (sw == 3'b010) ? ST2 : state_q;
      end
      ST2: begin
        led     = 3'b010;
        state_d = (sw == 3'b100) ? ST3 : state_q;
      end
      ST3: begin
        led     = 3'b100;
        state_d = (sw == 3'b001) ? ST1 : (sw == 3'b010) ? ST2 : (sw == 3'b111) ? ST4 : state_q;
      end
      ST4: begin
        led     = 3'b111;
        state_d = (sw == 3'b100) ? ST3 : (sw == 3'b000) ? IDLE : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sw_led_fsm.sv
// tb_sw_led_fsm: directed and random checks of sw_led_fsm against a table-driven transition model
module tb_sw_led_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sw = 3'b000;
  logic [2:0] led;
  int n_cmp = 0;
  int n_err = 0;
  int nxt [5][8];
  logic [2:0] led_of [5];
  int m = 0;

  sw_led_fsm dut (.clk(clk), .reset(reset), .sw(sw), .led(led));

  always #5 clk = ~clk;

  // reference model: states 0..4 = IDLE,ST1..ST4, table of listed moves, everything else holds
  task automatic init_model();
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < 8; c++) nxt[s][c] = s;
    nxt[0][1] = 1; nxt[0][2] = 2;
    nxt[1][2] = 2;
    nxt[2][4] = 3;
    nxt[3][1] = 1; nxt[3][2] = 2; nxt[3][7] = 4;
    nxt[4][4] = 3; nxt[4][0] = 0;
    led_of[0] = 3'b000; led_of[1] = 3'b001; led_of[2] = 3'b010;
    led_of[3] = 3'b100; led_of[4] = 3'b111;
  endtask

  task automatic step(input logic r, input logic [2:0] s);
    @(negedge clk);
    reset = r;
    sw = s;
    @(posedge clk);
    m = r ? 0 : nxt[m][s];
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'b111);
      n_cmp++;
      if (led !== 3'b000) begin n_err++; $display("FAIL reset_hold%0d led=%b want=000", i, led); end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 3'b000);
      n_cmp++;
      if (led !== 3'b000) begin n_err++; $display("FAIL idle_hold%0d led=%b want=000", i, led); end
    end
  endtask

  task automatic test_idle_seq();
    logic [2:0] codes [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [2:0] want  [6] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, codes[i]);
      n_cmp++;
      if (led !== want[i] || led !== led_of[m]) begin
        n_err++; $display("FAIL idle_seq%0d sw=%b led=%b want=%b", i, codes[i], led, want[i]);
      end
    end
  endtask

  task automatic test_st3_st4();
    logic [2:0] codes [4] = '{3'b111, 3'b100, 3'b111, 3'b000};
    logic [2:0] want  [4] = '{3'b111, 3'b100, 3'b111, 3'b000};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, codes[i]);
      n_cmp++;
      if (led !== want[i] || led !== led_of[m]) begin
        n_err++; $display("FAIL st3_st4_%0d sw=%b led=%b want=%b", i, codes[i], led, want[i]);
      end
    end
  endtask

  task automatic test_st1_hold();
    step(1'b0, 3'b001);
    n_cmp++;
    if (led !== 3'b001) begin n_err++; $display("FAIL enter_st1 led=%b want=001", led); end
    for (int c = 4; c < 8; c++) begin
      step(1'b0, 3'(c));
      n_cmp++;
      if (led !== 3'b001 || led !== led_of[m]) begin
        n_err++; $display("FAIL st1_hold sw=%0d led=%b want=001", c, led);
      end
    end
  endtask

  task automatic test_reset_wins();
    step(1'b0, 3'b010);
    step(1'b0, 3'b100);
    step(1'b0, 3'b111);
    n_cmp++;
    if (led !== 3'b111) begin n_err++; $display("FAIL reach_st4 led=%b want=111", led); end
    step(1'b1, 3'b100);
    n_cmp++;
    if (led !== 3'b000) begin n_err++; $display("FAIL reset_wins led=%b want=000", led); end
    step(1'b0, 3'b000);
  endtask

  task automatic test_illegal();
    step(1'b0, 3'b010);
    @(negedge clk);
    sw = 3'b011;
    force dut.state_q = 3'b111;
    #1;
    n_cmp++;
    if (led !== 3'b000) begin n_err++; $display("FAIL illegal_led led=%b want=000", led); end
    release dut.state_q;
    @(posedge clk);
    #1;
    m = 0;
    n_cmp++;
    if (led !== 3'b000 || dut.state_q !== 3'b000) begin
      n_err++; $display("FAIL illegal_recover led=%b state=%b want=000/000", led, dut.state_q);
    end
    step(1'b0, 3'b001);
    n_cmp++;
    if (led !== 3'b001) begin n_err++; $display("FAIL after_recover led=%b want=001", led); end
  endtask

  task automatic test_random();
    logic r;
    logic [2:0] s;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 31) == 0);
      s = 3'($urandom_range(0, 7));
      step(r, s);
      n_cmp++;
      if (led !== led_of[m]) begin
        n_err++; $display("FAIL random%0d rst=%b sw=%b led=%b want=%b", i, r, s, led, led_of[m]);
      end
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_idle_seq();
    test_st3_st4();
    test_st1_hold();
    test_reset_wins();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
